// File: rtl/hlink_arb_pkg.sv
// Shared definitions for the core-to-core link write arbiter.
package hlink_arb_pkg;

  localparam int unsigned MAC_MULT_NUM   = 4;
  localparam int unsigned IDATA_WIDTH    = 8;
  localparam int unsigned CREDIT_MAX_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hlink_arb_if.sv
// Requester handshake, credit return and link write-port signals.
interface hlink_arb_if
  import hlink_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned DATA_WIDTH = MAC_MULT_NUM * IDATA_WIDTH,
  parameter int unsigned IDW        = idx_w(N_REQ)
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_ready;
  logic                        credit_ret;
  logic [DATA_WIDTH-1:0]       hlink_wdata;
  logic                        hlink_wen;
  logic [IDW-1:0]              grant_id;
  logic                        busy;
  logic                        credit_err;

  modport slave (
    input  req_valid, req_data, req_last, credit_ret,
    output req_ready, hlink_wdata, hlink_wen, grant_id, busy, credit_err
  );

  modport master (
    output req_valid, req_data, req_last, credit_ret,
    input  req_ready, hlink_wdata, hlink_wen, grant_id, busy, credit_err
  );

endinterface

// File: rtl/hlink_arb_rr_pick.sv
// Combinational round-robin picker: first request found searching upward from ptr_i+1.
module rr_pick #(
  parameter int unsigned N   = 3,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  int unsigned c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[c[IDW-1:0]]) begin
        any_o              = 1'b1;
        gnt_o[c[IDW-1:0]]  = 1'b1;
        idx_o              = c[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/hlink_arb.sv
// Packet-locking round-robin arbiter for a credit-controlled link write port.
module hlink_arb
  import hlink_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned DATA_WIDTH = MAC_MULT_NUM * IDATA_WIDTH,
  parameter int unsigned CREDIT_MAX = CREDIT_MAX_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  hlink_arb_if.slave bus
);

  localparam int unsigned    IDW       = idx_w(N_REQ);
  localparam logic [3:0]     CRED_FULL = 4'(CREDIT_MAX);
  localparam logic [IDW-1:0] PTR_RST   = IDW'(N_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [IDW-1:0]        owner_q, owner_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [3:0]            cred_q, cred_d;
  logic                  err_q, err_d;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [IDW-1:0]        gid_q;

  logic [N_REQ-1:0]      win_gnt;
  logic [IDW-1:0]        win_idx;
  logic                  win_any;
  logic [N_REQ-1:0]      ready;
  logic [IDW-1:0]        cur;
  logic                  accept;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (rr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cred_d   = cred_q;
    err_d    = err_q;
    ready    = '0;
    cur_data = '0;
    cur      = (state_q == LOCK) ? owner_q : win_idx;

    if (cred_q != '0) begin
      if (state_q == LOCK) ready[owner_q] = 1'b1;
      else                 ready          = win_gnt;
    end

    accept   = |(ready & bus.req_valid);
    cur_last = bus.req_last[cur];
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (cur == IDW'(i)) cur_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    if (accept) begin
      if (cur_last) begin
        state_d = IDLE;
        rr_d    = cur;
      end else if (state_q == IDLE) begin
        state_d = LOCK;
        owner_d = cur;
      end
    end

    // Simultaneous accept and return cancel out; overflow is dropped and flagged.
    if (accept && !bus.credit_ret) begin
      cred_d = cred_q - 4'd1;
    end else if (!accept && bus.credit_ret) begin
      if (cred_q >= CRED_FULL) err_d  = 1'b1;
      else                     cred_d = cred_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= PTR_RST;
      cred_q  <= CRED_FULL;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      wen_q   <= accept;
      if (accept) begin
        wdata_q <= cur_data;
        gid_q   <= cur;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.hlink_wen   = wen_q;
  assign bus.hlink_wdata = wdata_q;
  assign bus.grant_id    = gid_q;
  assign bus.busy        = (state_q == LOCK);
  assign bus.credit_err  = err_q;

  logic unused_any;
  assign unused_any = win_any;

endmodule

// File: doc/hlink_arb.md
HLINK_ARB -- requirements
Module: hlink_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters sharing one core-to-core link write port.
REQ-002 SHALL have parameter DATA_WIDTH, default MAC_MULT_NUM*IDATA_WIDTH, link beat width.
REQ-003 SHALL have parameter CREDIT_MAX, default 4, downstream buffer slots, range 1..15.
REQ-004 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  N_REQ*DATA_WIDTH  per-requester beat; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_last  input  N_REQ  marks the final beat of a packet.
REQ-009 SHALL have port req_ready  output  N_REQ  per-requester beat accept.
REQ-010 SHALL have port credit_ret  input  1  one credit returned by the downstream consumer per cycle asserted.
REQ-011 SHALL have port hlink_wdata  output  DATA_WIDTH  write data to the link buffer.
REQ-012 SHALL have port hlink_wen  output  1  write enable to the link buffer.
REQ-013 SHALL have port grant_id  output  clog2(N_REQ)  requester owning the last written beat.
REQ-014 SHALL have port busy  output  1  high while in LOCK.
REQ-015 SHALL have port credit_err  output  1  sticky credit-overflow flag.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and LOCK, with a registered owner index and a registered round-robin pointer rr_ptr.
REQ-017 In IDLE, SHALL select as winner the first requester with req_valid set, searching from rr_ptr+1 upward modulo N_REQ.
REQ-018 SHALL drive req_ready combinationally: in IDLE only the winner's bit is set, in LOCK only the owner's bit is set, and only when credit count > 0; all other bits are 0.
REQ-019 A beat SHALL be accepted in any cycle where req_valid[i] and req_ready[i] are both high.
REQ-020 On an accepted beat in IDLE with req_last=0, SHALL move to LOCK with owner set to the winner.
REQ-021 On an accepted beat with req_last=1 (from IDLE or LOCK), SHALL be in IDLE next cycle with rr_ptr set to that requester.
REQ-022 In LOCK, SHALL ignore every non-owner request until the owner's last beat is accepted; an owner valid gap or zero credits holds LOCK indefinitely.
REQ-023 Latency: an accepted beat SHALL appear on hlink_wdata with hlink_wen=1 and grant_id set exactly one cycle later.
REQ-024 hlink_wen SHALL be 0 in cycles with no accepted beat; hlink_wdata and grant_id SHALL hold their prior values in those cycles.
REQ-025 A 4-bit credit counter SHALL reset to CREDIT_MAX, decrement on each accepted beat, and increment on credit_ret.
REQ-026 When an accept and credit_ret occur in the same cycle, the credit counter SHALL stay unchanged.
REQ-027 A credit_ret that would raise the counter above CREDIT_MAX SHALL leave the counter unchanged and set credit_err, which stays set until reset.
REQ-028 The counter SHALL never underflow, because req_ready is 0 when credits are 0.
REQ-029 busy SHALL equal (state==LOCK), registered.

Reset
REQ-030 On rstn low, SHALL asynchronously set: state=IDLE, owner=0, rr_ptr=N_REQ-1 (so requester 0 has first priority), credit counter=CREDIT_MAX, hlink_wen=0, hlink_wdata=0, grant_id=0, busy=0, credit_err=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after reset the block resumes from IDLE with full credits.

Structure
REQ-032 The shared sys_defs package/header SHALL hold the FSM state enum (IDLE, LOCK) and the default CREDIT_MAX; DATA_WIDTH SHALL derive from the existing MAC_MULT_NUM and IDATA_WIDTH.
REQ-033 A combinational round-robin priority picker SHALL be a sub-module named rr_pick (inputs: request vector, pointer; outputs: one-hot grant, index, any).

Verification
REQ-034 Single beat: requester 1 valid, last=1, data 0xA5 at cycle 0 -> req_ready[1]=1 at cycle 0; hlink_wen=1, hlink_wdata=0xA5, grant_id=1 at cycle 1; credits go from 4 to 3.
REQ-035 Packet lock: requester 0 sends a 3-beat packet while requester 2 is continuously valid -> requester 2 receives no ready until the cycle after requester 0's last beat, then is granted.
REQ-036 Round-robin: all three requesters send 1-beat packets back-to-back with credit_ret every cycle -> grant_id sequence is 0,1,2,0,1,2.
REQ-037 Credit stall: CREDIT_MAX=4, no credit_ret, requester 0 streams 6 beats -> exactly 4 writes, then req_ready=0 and busy=1; one credit_ret pulse releases exactly one more beat.
REQ-038 Boundaries: accept and credit_ret in the same cycle -> count unchanged; credit_ret at count 4 -> credit_err=1 and count stays 4; rstn pulse mid-packet -> all outputs return to reset values and credits return to 4.
